// File: rtl/dmac_ch0_sequencer.sv
// -----------------------------------------------------------------------------
// dmac_ch0_sequencer
//
// Channel-0 transfer sequencer of the DMAC. It sits between the register bank
// and the AHB master port. While channel 0 is enabled it copies
// source -> data buffer -> destination as repeated bursts: a read burst
// followed by a write burst. It strobes the bank's load, increment and
// decrement controls, and raises the channel-done interrupt when the
// transfer completes.
//
// Ports
//   r_HCLK, r_HRESET          clock, asynchronous active-high reset
//   CHANNEL_enable            channel-0 enable from the bank
//   TS[11:0]                  remaining bytes; the bank subtracts 4 per
//                             TransferSize_dec_flag
//   BS[2:0]                   burst code, beats = min(BS+1, BUF_DEPTH)
//   DMACINTR_mask             1 masks DMACINTR
//   sync_grant, m_HREADY      registered HGRANT, AHB ready
//   m_HBUSREQ, m_HTRANS,
//   m_HWRITE, addr_sel        AHB master controls and address mux select
//   load_DMAC_C0_Addr .. set_DMACINTR_status
//                             one-cycle strobes to the bank and buffer
//   DMACINTR                  level interrupt, pending & ~mask
//   busy                      high whenever the FSM is not IDLE
//   dbg_state[2:0]            current FSM state, IDLE encodes as 0
//
// Bus handshake: an address phase is offered while m_HTRANS != IDLE and is
// accepted on the cycle m_HREADY=1. Its data phase occupies the following
// cycle(s) and completes on the next cycle with m_HREADY=1. A cycle with
// m_HREADY=0 completes nothing, so outputs hold and no strobe fires.
// -----------------------------------------------------------------------------
module dmac_ch0_sequencer #(
    parameter int BUF_DEPTH = 4,
    parameter int BUF_AW    = 2
) (
    input  logic        r_HCLK,
    input  logic        r_HRESET,
    input  logic        CHANNEL_enable,
    input  logic [11:0] TS,
    input  logic [2:0]  BS,
    input  logic        DMACINTR_mask,
    input  logic        sync_grant,
    input  logic        m_HREADY,
    output logic        m_HBUSREQ,
    output logic [1:0]  m_HTRANS,
    output logic        m_HWRITE,
    output logic        addr_sel,
    output logic        load_DMAC_C0_Addr,
    output logic        src_addr_inc,
    output logic        dest_addr_inc,
    output logic        TransferSize_dec_flag,
    output logic        buffer_idx_inc,
    output logic        buffer_zero_flag,
    output logic        src_burst_zero_flag,
    output logic        dest_burst_zero_flag,
    output logic        CHANNEL_dis_flag,
    output logic        set_DMACINTR_status,
    output logic        DMACINTR,
    output logic        busy,
    output logic [2:0]  dbg_state
);
    localparam int CW = BUF_AW + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_RE   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] addr_cnt_q, addr_cnt_d;   // address phases accepted
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;   // data beats completed
    logic [CW-1:0] burst_len_q, burst_len_d;
    logic          dphase_q, dphase_d;       // a data phase is outstanding
    logic          pending_q, pending_d;

    logic [10:0]   beats_cap;
    logic [CW-1:0] burst_calc;
    logic          xfer_phase, addr_left, addr_acc, data_done, last_data;
    logic          unused_ts_bits;

    // Byte offset inside a word has no effect on the word count.
    assign unused_ts_bits = ^TS[1:0];

    // Burst length = min(BS+1, BUF_DEPTH, remaining words).
    always_comb begin
        beats_cap = {8'd0, BS} + 11'd1;
        if (beats_cap > 11'(BUF_DEPTH)) beats_cap = 11'(BUF_DEPTH);
        if ({1'b0, TS[11:2]} < beats_cap) beats_cap = {1'b0, TS[11:2]};
    end
    assign burst_calc = beats_cap[CW-1:0];

    assign xfer_phase = (state_q == S_RD) || (state_q == S_WR);
    assign addr_left  = addr_cnt_q < burst_len_q;
    assign addr_acc   = xfer_phase && addr_left && m_HREADY;
    assign data_done  = xfer_phase && dphase_q && m_HREADY;
    assign last_data  = data_done && (beat_cnt_q == burst_len_q - 1'b1);

    // State register.
    always_ff @(posedge r_HCLK or posedge r_HRESET) begin
        if (r_HRESET) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (CHANNEL_enable) state_d = S_LOAD;
            S_LOAD: state_d = (TS[11:2] == 10'd0) ? S_DONE : S_REQ;
            S_REQ:  if (sync_grant && m_HREADY) state_d = S_RD;
            S_RD:   if (last_data) state_d = S_WR;
            S_WR: begin
                // Final word wins over an abort so a finished transfer
                // always reports completion.
                if (last_data) begin
                    if (TS[11:2] == 10'd1)    state_d = S_DONE;
                    else if (!CHANNEL_enable) state_d = S_IDLE;
                    else                      state_d = S_RE;
                end
            end
            S_RE:   state_d = S_REQ;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst counters and interrupt pending bit.
    always_comb begin
        addr_cnt_d  = addr_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        dphase_d    = dphase_q;
        burst_len_d = burst_len_q;
        pending_d   = pending_q;
        if (xfer_phase && !last_data) begin
            if (addr_acc)  addr_cnt_d = addr_cnt_q + 1'b1;
            if (data_done) beat_cnt_d = beat_cnt_q + 1'b1;
            if (m_HREADY)  dphase_d   = addr_acc;
        end else begin
            // Every phase starts with clean counters.
            addr_cnt_d = '0;
            beat_cnt_d = '0;
            dphase_d   = 1'b0;
        end
        // RE sees TS already decremented by the bank for the last burst.
        if (state_q == S_LOAD || state_q == S_RE) burst_len_d = burst_calc;
        if (state_q == S_IDLE && CHANNEL_enable) pending_d = 1'b0;
        if (state_q == S_DONE) pending_d = 1'b1;
    end

    always_ff @(posedge r_HCLK or posedge r_HRESET) begin
        if (r_HRESET) begin
            addr_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            dphase_q    <= 1'b0;
            burst_len_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            addr_cnt_q  <= addr_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            dphase_q    <= dphase_d;
            burst_len_q <= burst_len_d;
            pending_q   <= pending_d;
        end
    end

    // Output logic.
    always_comb begin
        m_HBUSREQ             = 1'b0;
        m_HTRANS              = 2'b00;
        m_HWRITE              = 1'b0;
        addr_sel              = 1'b0;
        load_DMAC_C0_Addr     = 1'b0;
        src_addr_inc          = 1'b0;
        dest_addr_inc         = 1'b0;
        TransferSize_dec_flag = 1'b0;
        buffer_idx_inc        = 1'b0;
        buffer_zero_flag      = 1'b0;
        src_burst_zero_flag   = 1'b0;
        dest_burst_zero_flag  = 1'b0;
        CHANNEL_dis_flag      = 1'b0;
        set_DMACINTR_status   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CHANNEL_enable) begin
                    load_DMAC_C0_Addr    = 1'b1;
                    buffer_zero_flag     = 1'b1;
                    src_burst_zero_flag  = 1'b1;
                    dest_burst_zero_flag = 1'b1;
                end
            end
            S_REQ: m_HBUSREQ = 1'b1;
            S_RD, S_WR: begin
                m_HBUSREQ      = 1'b1;
                m_HWRITE       = (state_q == S_WR);
                addr_sel       = (state_q == S_WR);
                if (addr_left) m_HTRANS = (addr_cnt_q == '0) ? 2'b10 : 2'b11;
                buffer_idx_inc = data_done;
                if (state_q == S_RD) begin
                    src_addr_inc = addr_acc;
                    if (last_data) begin
                        buffer_zero_flag     = 1'b1;
                        dest_burst_zero_flag = 1'b1;
                    end
                end else begin
                    dest_addr_inc         = addr_acc;
                    TransferSize_dec_flag = data_done;
                end
            end
            S_RE: begin
                m_HBUSREQ           = 1'b1;
                buffer_zero_flag    = 1'b1;
                src_burst_zero_flag = 1'b1;
            end
            S_DONE: begin
                CHANNEL_dis_flag    = 1'b1;
                set_DMACINTR_status = 1'b1;
            end
            default: ;
        endcase
    end

    assign DMACINTR  = pending_q & ~DMACINTR_mask;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmac_ch0_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dmac_ch0_sequencer
//
// Drives channel-0 transfers with random bus stalls and grant delays. A small
// register-bank model decrements TS and clears the enable. Expected bus
// address phases come from the word count and the burst rule alone.
// -----------------------------------------------------------------------------
module tb_dmac_ch0_sequencer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        CHANNEL_enable;
    logic [11:0] TS;
    logic [2:0]  BS;
    logic        DMACINTR_mask, sync_grant, m_HREADY;
    logic        m_HBUSREQ, m_HWRITE, addr_sel, load_DMAC_C0_Addr;
    logic [1:0]  m_HTRANS;
    logic        src_addr_inc, dest_addr_inc, TransferSize_dec_flag, buffer_idx_inc;
    logic        buffer_zero_flag, src_burst_zero_flag, dest_burst_zero_flag;
    logic        CHANNEL_dis_flag, set_DMACINTR_status, DMACINTR, busy;
    logic [2:0]  dbg_state;

    dmac_ch0_sequencer #(.BUF_DEPTH(DEPTH), .BUF_AW(2)) dut (
        .r_HCLK(clk), .r_HRESET(rst), .CHANNEL_enable(CHANNEL_enable), .TS(TS), .BS(BS),
        .DMACINTR_mask(DMACINTR_mask), .sync_grant(sync_grant), .m_HREADY(m_HREADY),
        .m_HBUSREQ(m_HBUSREQ), .m_HTRANS(m_HTRANS), .m_HWRITE(m_HWRITE), .addr_sel(addr_sel),
        .load_DMAC_C0_Addr(load_DMAC_C0_Addr), .src_addr_inc(src_addr_inc),
        .dest_addr_inc(dest_addr_inc), .TransferSize_dec_flag(TransferSize_dec_flag),
        .buffer_idx_inc(buffer_idx_inc), .buffer_zero_flag(buffer_zero_flag),
        .src_burst_zero_flag(src_burst_zero_flag), .dest_burst_zero_flag(dest_burst_zero_flag),
        .CHANNEL_dis_flag(CHANNEL_dis_flag), .set_DMACINTR_status(set_DMACINTR_status),
        .DMACINTR(DMACINTR), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard: entries are {addr_sel, hwrite, htrans}
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int checks = 0;
    int errors = 0;

    int  k, dis_k, first_nonseq_k;
    int  n_src, n_dest, n_dec, n_idx, n_dis, n_set, n_load, n_busreq;
    int  stall_pct, miss_pct, force_k;
    bit  prev_stall, last_busy, saw_dec, saw_dis;
    logic [3:0] prev_phase;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        m_HREADY   = ($urandom_range(99) >= stall_pct);
        sync_grant = ($urandom_range(99) >= miss_pct);
        if (force_k >= 0 && (k == force_k || k == force_k + 1)) m_HREADY = 1'b0;
    endtask

    // One clock: monitor at negedge, then bank model and new bus inputs after posedge.
    task automatic cycle();
        @(negedge clk);
        if (m_HREADY && m_HTRANS != 2'b00) obs_q.push_back({addr_sel, m_HWRITE, m_HTRANS});
        if (m_HTRANS == 2'b10 && first_nonseq_k < 0) first_nonseq_k = k;
        n_src    += int'(src_addr_inc);
        n_dest   += int'(dest_addr_inc);
        n_dec    += int'(TransferSize_dec_flag);
        n_idx    += int'(buffer_idx_inc);
        n_set    += int'(set_DMACINTR_status);
        n_load   += int'(load_DMAC_C0_Addr);
        n_busreq += int'(m_HBUSREQ);
        if (CHANNEL_dis_flag) begin
            n_dis++;
            if (dis_k < 0) dis_k = k;
        end
        if (!m_HREADY && busy)
            check_eq("stall_strobes",
                     {28'd0, src_addr_inc, dest_addr_inc, TransferSize_dec_flag, buffer_idx_inc}, 32'd0);
        if (prev_stall)
            check_eq("stall_freeze", {28'd0, addr_sel, m_HWRITE, m_HTRANS}, {28'd0, prev_phase});
        prev_stall = !m_HREADY && (m_HTRANS != 2'b00);
        prev_phase = {addr_sel, m_HWRITE, m_HTRANS};
        last_busy  = busy;
        saw_dec    = TransferSize_dec_flag;
        saw_dis    = CHANNEL_dis_flag;
        @(posedge clk);
        #1;
        if (saw_dec) TS = TS - 12'd4;
        if (saw_dis) CHANNEL_enable = 1'b0;
        k++;
        drive_bus();
    endtask

    task automatic run_xfer(input int ts_in, input int bs_in, input bit mask_in,
                            input int st, input int ms, input int fk, input bit abort);
        int words, c, done_words, rem, n;
        bit finished;
        words = (ts_in >> 2) & 1023;
        c = (bs_in + 1 > DEPTH) ? DEPTH : bs_in + 1;
        done_words = abort ? c : words;
        exp_q.delete();
        obs_q.delete();
        rem = done_words;
        while (rem > 0) begin
            n = (rem < c) ? rem : c;
            for (int i = 0; i < n; i++) exp_q.push_back({2'b00, (i == 0) ? 2'b10 : 2'b11});
            for (int i = 0; i < n; i++) exp_q.push_back({2'b11, (i == 0) ? 2'b10 : 2'b11});
            rem -= n;
        end
        k = 0; dis_k = -1; first_nonseq_k = -1; prev_stall = 0;
        n_src = 0; n_dest = 0; n_dec = 0; n_idx = 0; n_dis = 0; n_set = 0; n_load = 0; n_busreq = 0;
        stall_pct = st; miss_pct = ms; force_k = fk;
        TS = ts_in[11:0]; BS = bs_in[2:0]; DMACINTR_mask = mask_in; CHANNEL_enable = 1'b1;
        drive_bus();
        finished = 0;
        for (int t = 0; t < 3000 && !finished; t++) begin
            cycle();
            if (abort && first_nonseq_k >= 0) CHANNEL_enable = 1'b0;
            if (!abort && dis_k >= 0) finished = 1;
            if (abort && k > 4 && !last_busy) finished = 1;
        end
        check_eq("finished", {31'd0, finished}, 32'd1);
        if (!abort) begin
            @(negedge clk);
            check_eq("intr_after_done", {31'd0, DMACINTR}, {31'd0, ~mask_in});
            check_eq("dis_one_cycle", {31'd0, CHANNEL_dis_flag}, 32'd0);
            check_eq("idle_after_done", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
        end else begin
            check_eq("abort_intr", {31'd0, DMACINTR}, 32'd0);
            for (int i = 0; i < 4; i++) cycle();
            check_eq("abort_stays_idle", {31'd0, last_busy}, 32'd0);
        end
        check_eq("n_phases", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq($sformatf("phase%0d", i), {28'd0, obs_q[i]}, {28'd0, exp_q[i]});
        check_eq("n_src_inc", n_src, done_words);
        check_eq("n_dest_inc", n_dest, done_words);
        check_eq("n_ts_dec", n_dec, done_words);
        check_eq("n_idx_inc", n_idx, 2 * done_words);
        check_eq("n_dis", n_dis, abort ? 0 : 1);
        check_eq("n_set_status", n_set, abort ? 0 : 1);
        check_eq("n_load", n_load, 1);
        if (words == 0) begin
            check_eq("ts0_done_k", dis_k, 2);
            check_eq("ts0_busreq", n_busreq, 0);
        end
        if (st == 0 && ms == 0 && fk < 0 && words > 0)
            check_eq("latency_nonseq", first_nonseq_k, 3);
    endtask

    initial begin
        int w, ts, bs, c;
        bit ab;
        rst = 1'b1;
        CHANNEL_enable = 1'b0; TS = '0; BS = '0; DMACINTR_mask = 1'b0;
        sync_grant = 1'b0; m_HREADY = 1'b1;
        stall_pct = 0; miss_pct = 0; force_k = -1; k = 0;
        @(negedge clk);
        check_eq("reset_outputs",
                 {15'd0, m_HBUSREQ, m_HTRANS, m_HWRITE, addr_sel, load_DMAC_C0_Addr, src_addr_inc,
                  dest_addr_inc, TransferSize_dec_flag, buffer_idx_inc, buffer_zero_flag,
                  src_burst_zero_flag, dest_burst_zero_flag, CHANNEL_dis_flag,
                  set_DMACINTR_status, DMACINTR, busy}, 32'd0);
        check_eq("reset_state", {29'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_xfer(16, 3, 0, 0, 0, -1, 0);   // one 4-beat burst
        run_xfer(40, 1, 0, 0, 0, -1, 0);   // five 2-beat bursts
        run_xfer(12, 7, 0, 0, 0, -1, 0);   // one 3-beat burst, clamped by TS
        run_xfer(8, 0, 0, 0, 0, 3, 0);     // two-cycle stall on the first read address
        run_xfer(32, 3, 0, 0, 0, -1, 1);   // enable dropped in burst 1 read
        run_xfer(0, 2, 1, 0, 0, -1, 0);    // empty transfer, interrupt masked
        DMACINTR_mask = 1'b0;
        #1;
        check_eq("pending_unmask", {31'd0, DMACINTR}, 32'd1);

        // Reset in the middle of a read burst
        stall_pct = 0; miss_pct = 0; force_k = -1; k = 0;
        TS = 12'd64; BS = 3'd3; CHANNEL_enable = 1'b1; m_HREADY = 1'b1; sync_grant = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        #2;
        rst = 1'b1;
        CHANNEL_enable = 1'b0;
        #1;
        check_eq("midrst_htrans", {30'd0, m_HTRANS}, 32'd0);
        check_eq("midrst_outputs",
                 {26'd0, m_HBUSREQ, src_addr_inc, dest_addr_inc, TransferSize_dec_flag,
                  buffer_idx_inc, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_intr", {31'd0, DMACINTR}, 32'd0);

        for (int r = 0; r < 20; r++) begin
            w  = $urandom_range(0, 20);
            ts = w * 4 + $urandom_range(0, 3);
            bs = $urandom_range(0, 7);
            c  = (bs + 1 > DEPTH) ? DEPTH : bs + 1;
            ab = (w > c) && ($urandom_range(0, 3) == 0);
            run_xfer(ts, bs, $urandom_range(0, 1), $urandom_range(0, 30),
                     $urandom_range(0, 40), -1, ab);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
